sar_ctrl_10b: RTL and testbench

- Synchronous successive-approximation controller for the 10-bit SAR ADC.
- Sits directly upstream of the differential CDAC / reference-resistor switch array, driving its positive and negative switch controls.
- Sequences sample, per-bit comparator strobe and decision, and output-word delivery.
- Consumes the comparator decision and delivers a 10-bit code with a one-cycle valid pulse.

---
 rtl/sar_pkg.sv | 28 ++
 rtl/sar_cmp_watchdog.sv | 39 +++
 rtl/sar_ctrl_10b.sv | 141 ++++++++++++++
 tb/tb_sar_ctrl_10b.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
//------------------------------------------------------------------------------
// Module   : sar_pkg
// Brief    : Shared types, default constants and trial-word helper for the SAR
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sar_pkg;

  localparam int unsigned c_nbit        = 10;
  localparam int unsigned c_sample_cyc  = 4;
  localparam int unsigned c_cmp_timeout = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    COMPARE = 3'd2,
    DECIDE  = 3'd3,
    DONE    = 3'd4
  } sar_state_t;

  function automatic logic [31:0] trial_word(input logic [31:0] result, input logic [4:0] idx);
    trial_word = result | (32'd1 << idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_cmp_watchdog.sv
//------------------------------------------------------------------------------
// Module   : sar_cmp_watchdog
// Brief    : Per-bit comparator wait counter; pulses expire when CMP_RDY is late
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sar_cmp_watchdog
  import sar_pkg::*;
#(
  parameter int unsigned CMP_TIMEOUT = c_cmp_timeout
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic cmp_rdy,
  output logic expire
);

  localparam int unsigned c_cw = $clog2(CMP_TIMEOUT + 1);

  logic [c_cw-1:0] r_cnt;

  // Counts completed wait cycles; held at zero outside the wait window, saturating inside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (r_cnt != c_cw'(CMP_TIMEOUT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire = !restart && !cmp_rdy && (r_cnt == c_cw'(CMP_TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/sar_ctrl_10b.sv
//------------------------------------------------------------------------------
// Module   : sar_ctrl_10b
// Brief    : 10-bit SAR sequencer driving differential CDAC switches
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sar_ctrl_10b
  import sar_pkg::*;
#(
  parameter int unsigned NBIT        = c_nbit,
  parameter int unsigned SAMPLE_CYC  = c_sample_cyc,
  parameter int unsigned CMP_TIMEOUT = c_cmp_timeout
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cmp_out,
  input  logic            cmp_rdy,
  output logic            smpl,
  output logic            cmp_en,
  output logic [NBIT-1:0] dac_p,
  output logic [NBIT-1:0] dac_n,
  output logic [NBIT-1:0] dout,
  output logic            dvalid,
  output logic            busy,
  output logic            timeout_flag
);

  localparam int unsigned c_iw  = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int unsigned c_scw = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

  sar_state_t       r_state;
  logic [c_iw-1:0]  r_idx;
  logic [NBIT-1:0]  r_result;
  logic [c_scw-1:0] r_scnt;

  logic            w_restart;
  logic            w_expire;
  logic            w_dec;
  logic [NBIT-1:0] w_trial;
  logic [NBIT-1:0] w_trial_nxt;
  logic [NBIT-1:0] w_res_upd;

  assign w_restart   = (r_state != COMPARE);
  assign w_dec       = cmp_rdy & cmp_out;
  assign w_trial     = NBIT'(trial_word(32'(r_result), 5'(r_idx)));
  assign w_trial_nxt = NBIT'(trial_word(32'(r_result), 5'(r_idx - 1'b1)));
  assign w_res_upd   = r_result | (NBIT'(w_dec) << r_idx);

  sar_cmp_watchdog #(
    .CMP_TIMEOUT (CMP_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (w_restart),
    .cmp_rdy (cmp_rdy),
    .expire  (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= c_iw'(NBIT - 1);
      r_result     <= '0;
      r_scnt       <= '0;
      smpl         <= 1'b0;
      cmp_en       <= 1'b0;
      dac_p        <= '0;
      dac_n        <= '0;
      dout         <= '0;
      dvalid       <= 1'b0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= SAMPLE;
            r_idx        <= c_iw'(NBIT - 1);
            r_result     <= '0;
            r_scnt       <= '0;
            smpl         <= 1'b1;
            busy         <= 1'b1;
            timeout_flag <= 1'b0;
          end
        end
        SAMPLE: begin
          if (r_scnt == c_scw'(SAMPLE_CYC - 1)) begin
            r_state <= COMPARE;
            smpl    <= 1'b0;
            cmp_en  <= 1'b1;
            dac_p   <= w_trial;
            dac_n   <= ~w_trial;
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end
        COMPARE: begin
          // A watchdog expiry forces a zero decision because w_dec is gated by cmp_rdy
          if (cmp_rdy || w_expire) begin
            r_state  <= DECIDE;
            cmp_en   <= 1'b0;
            r_result <= w_res_upd;
            dac_p    <= w_res_upd;
            dac_n    <= ~w_res_upd;
            if (!cmp_rdy) begin
              timeout_flag <= 1'b1;
            end
          end
        end
        DECIDE: begin
          if (r_idx == '0) begin
            r_state <= DONE;
            dout    <= r_result;
            dvalid  <= 1'b1;
            busy    <= 1'b0;
            dac_p   <= '0;
            dac_n   <= '0;
          end else begin
            r_state <= COMPARE;
            r_idx   <= r_idx - 1'b1;
            cmp_en  <= 1'b1;
            dac_p   <= w_trial_nxt;
            dac_n   <= ~w_trial_nxt;
          end
        end
        DONE: begin
          r_state <= IDLE;
          dvalid  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sar_ctrl_10b.sv
//------------------------------------------------------------------------------
// Module   : tb_sar_ctrl_10b
// Brief    : Randomized self-checking bench for sar_ctrl_10b with comparator model
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sar_ctrl_10b;

  localparam int NBIT        = 10;
  localparam int SAMPLE_CYC  = 4;
  localparam int CMP_TIMEOUT = 8;
  localparam int MASK        = (1 << NBIT) - 1;
  localparam int WITHHELD    = CMP_TIMEOUT + 50;

  logic clk = 1'b0;
  logic rst_n, start, cmp_out, cmp_rdy;
  logic smpl, cmp_en, dvalid, busy, timeout_flag;
  logic [NBIT-1:0] dac_p, dac_n, dout;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int dv_cnt = 0;

  int vin = 0;
  int exp_code = 0;
  int rdy_dly[NBIT];
  int cur_bit = NBIT;
  int en_cyc = 0;
  int low_run = 0;
  int smpl_cyc = 0;
  logic prev_en = 1'b0;

  sar_ctrl_10b #(
    .NBIT        (NBIT),
    .SAMPLE_CYC  (SAMPLE_CYC),
    .CMP_TIMEOUT (CMP_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cmp_out      (cmp_out),
    .cmp_rdy      (cmp_rdy),
    .smpl         (smpl),
    .cmp_en       (cmp_en),
    .dac_p        (dac_p),
    .dac_n        (dac_n),
    .dout         (dout),
    .dvalid       (dvalid),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ideal comparator: keeps a bit when vin is at or above the trial level
  task automatic plan(output int code, output logic tflag, output int lat);
    code  = 0;
    tflag = 1'b0;
    lat   = SAMPLE_CYC;
    for (int b = NBIT - 1; b >= 0; b--) begin
      if (rdy_dly[b] > CMP_TIMEOUT) begin
        tflag = 1'b1;
        lat += CMP_TIMEOUT + 1;
      end else begin
        lat += rdy_dly[b] + 1;
        if (vin >= (code | (1 << b))) code = code | (1 << b);
      end
    end
  endtask

  task automatic set_dly(input int d);
    for (int b = 0; b < NBIT; b++) rdy_dly[b] = d;
  endtask

  // Comparator environment plus per-cycle DAC and strobe-gap checks
  initial begin
    int t;
    cmp_rdy = 1'b0;
    cmp_out = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 1'b0;
        cmp_rdy = 1'b0;
        cmp_out = 1'b0;
      end else begin
        if (dvalid) dv_cnt++;
        if (smpl) begin
          smpl_cyc++;
          cur_bit = NBIT;
          low_run = 0;
        end
        if (cmp_en) begin
          if (!prev_en) begin
            if (cur_bit != NBIT) check_eq("cmp_gap", low_run, 1);
            cur_bit--;
            en_cyc = 0;
          end
          en_cyc++;
          low_run = 0;
          t = ((exp_code >> (cur_bit + 1)) << (cur_bit + 1)) | (1 << cur_bit);
          if (en_cyc == 1) begin
            check_eq("dac_p_trial", dac_p, t);
            check_eq("dac_n_trial", dac_n, t ^ MASK);
          end
          if (cur_bit >= 0 && en_cyc >= rdy_dly[cur_bit]) begin
            cmp_rdy = 1'b1;
            cmp_out = (vin >= int'(dac_p));
          end else begin
            cmp_rdy = 1'b0;
            cmp_out = 1'($urandom);
          end
        end else begin
          if (busy && !smpl && cur_bit >= 0 && cur_bit < NBIT) begin
            low_run++;
            t = (exp_code >> cur_bit) << cur_bit;
            check_eq("dac_p_decide", dac_p, t);
            check_eq("dac_n_decide", dac_n, t ^ MASK);
          end
          cmp_rdy = 1'($urandom);
          cmp_out = 1'($urandom);
        end
        prev_en = cmp_en;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || dvalid) && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic run_conv(input string tag, input bit noise);
    int code, lat, k, dv0, t;
    logic tf;
    plan(code, tf, lat);
    exp_code = code;
    wait_idle();
    smpl_cyc = 0;
    dv0 = dv_cnt;
    start = 1'b1;
    k = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, ":sample"}, {smpl, busy, timeout_flag}, 3'b110);
    t = 0;
    while (!dvalid && t < 400) begin
      if (noise) start = 1'($urandom);
      @(negedge clk);
      t++;
    end
    start = noise;
    check_eq({tag, ":dvalid"}, dvalid, 1'b1);
    if (dvalid) begin
      // DVALID lands in cycle k+1+lat in the one-based cycle numbering
      check_eq({tag, ":latency"}, edge_cnt - k, lat);
      check_eq({tag, ":dout"}, dout, code);
      check_eq({tag, ":tflag"}, timeout_flag, tf);
      check_eq({tag, ":busy_done"}, busy, 1'b0);
      check_eq({tag, ":smpl_cyc"}, smpl_cyc, SAMPLE_CYC);
      @(negedge clk);
      start = 1'b0;
      check_eq({tag, ":dv_pulse"}, dvalid, 1'b0);
      check_eq({tag, ":tflag_hold"}, timeout_flag, tf);
      check_eq({tag, ":dv_count"}, dv_cnt - dv0, 1);
      @(negedge clk);
      check_eq({tag, ":start_ignored"}, busy, 1'b0);
    end
  endtask

  initial begin
    int code, lat, k, e1, t;
    logic tf;
    rst_n = 1'b0;
    start = 1'b0;
    set_dly(1);
    repeat (2) @(negedge clk);
    check_eq("reset_outs", {smpl, cmp_en, dvalid, busy, timeout_flag, dac_p, dac_n, dout}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vin = 'h2A5; set_dly(1);
    run_conv("ideal", 1'b0);
    vin = 'h3FF; set_dly(1);
    run_conv("all_ones", 1'b0);
    vin = 0; set_dly(1);
    run_conv("all_zeros", 1'b0);
    vin = 'h3FF; set_dly(1); rdy_dly[3] = WITHHELD;
    run_conv("timeout_b3", 1'b0);
    vin = 'h1C6; set_dly(3);
    run_conv("slow", 1'b0);
    vin = 'h155; set_dly(CMP_TIMEOUT);
    run_conv("rdy_at_limit", 1'b1);

    for (int i = 0; i < 10; i++) begin
      vin = int'($urandom_range(0, MASK));
      for (int b = 0; b < NBIT; b++)
        rdy_dly[b] = ($urandom_range(0, 7) == 0) ? WITHHELD : int'($urandom_range(1, CMP_TIMEOUT));
      run_conv($sformatf("rand%0d", i), 1'($urandom));
    end

    // START held: back-to-back conversions separated by one IDLE cycle
    vin = int'($urandom_range(1, MASK)); set_dly(1);
    plan(code, tf, lat);
    exp_code = code;
    wait_idle();
    start = 1'b1;
    k = edge_cnt + 1;
    t = 0;
    while (!dvalid && t < 200) begin @(negedge clk); t++; end
    check_eq("b2b:dv1", dvalid, 1'b1);
    e1 = edge_cnt;
    check_eq("b2b:lat1", e1 - k, lat);
    check_eq("b2b:dout1", dout, code);
    @(negedge clk);
    t = 0;
    while (!dvalid && t < 200) begin @(negedge clk); t++; end
    start = 1'b0;
    check_eq("b2b:dv2", dvalid, 1'b1);
    check_eq("b2b:gap", edge_cnt - e1, lat + 2);
    check_eq("b2b:dout2", dout, code);
    @(negedge clk);

    // Reset asserted during the bit-5 compare aborts the conversion
    vin = int'($urandom_range(0, MASK)); set_dly(1);
    plan(code, tf, lat);
    exp_code = code;
    wait_idle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(cmp_en && dac_p[5] && dac_p[4:0] == 5'd0) && t < 100) begin @(negedge clk); t++; end
    check_eq("rst:reached_b5", cmp_en, 1'b1);
    e1 = dv_cnt;
    #2 rst_n = 1'b0;
    #1 check_eq("rst:async_outs", {smpl, cmp_en, dvalid, busy, timeout_flag, dac_p, dac_n, dout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("rst:no_dvalid", dv_cnt - e1, 0);
    check_eq("rst:dout", dout, 0);
    check_eq("rst:busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
